// File: rtl/pdm_clock_gen.sv
// PDM microphone clock generator: qualifies PLL lock, releases a downstream
// reset, and divides the PLL clock into pdm_clk with rise/fall/sample strobes.
module pdm_clock_gen #(
  parameter int CLK_DIV   = 32,
  parameter int LOCK_WAIT = 1024,
  parameter int DECIM     = 64
) (
  input  logic clock,
  input  logic reset_n,
  input  logic locked,
  input  logic enable,
  output logic sys_reset_n,
  output logic pdm_clk,
  output logic pdm_rise,
  output logic pdm_fall,
  output logic sample_stb
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int PDM_W = $clog2(DECIM);
  localparam int SET_W = $clog2(LOCK_WAIT) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [PDM_W-1:0] PDM_LAST = PDM_W'(DECIM - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(LOCK_WAIT - 1);

  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_e;

  state_e             state_q;
  logic [1:0]         sync_q;
  logic [SET_W-1:0]   settle_cnt_q;
  logic               sys_rst_n_q;
  logic               locked_s;

  assign locked_s = sync_q[1];

  // Lock qualification FSM; sys_reset_n is registered alongside the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q       <= '0;
      state_q      <= WAIT_LOCK;
      settle_cnt_q <= '0;
      sys_rst_n_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], locked};
      case (state_q)
        WAIT_LOCK: begin
          settle_cnt_q <= '0;
          if (locked_s) state_q <= SETTLE;
        end
        SETTLE: begin
          if (!locked_s) begin
            state_q      <= WAIT_LOCK;
            settle_cnt_q <= '0;
          end else if (settle_cnt_q == SET_LAST) begin
            state_q      <= RUN;
            settle_cnt_q <= '0;
            sys_rst_n_q  <= 1'b1;
          end else begin
            settle_cnt_q <= settle_cnt_q + SET_W'(1);
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_q     <= WAIT_LOCK;
            sys_rst_n_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= WAIT_LOCK;
          settle_cnt_q <= '0;
          sys_rst_n_q  <= 1'b0;
        end
      endcase
    end
  end

  logic             active_q, active_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [PDM_W-1:0] pdm_cnt_q, pdm_cnt_d;
  logic             clk_q, clk_d, rise_q, rise_d, fall_q, fall_d, stb_q, stb_d;

  // Lost lock kills the datapath on the same edge the FSM leaves RUN.
  assign active_d = (state_q == RUN) && locked_s && enable;

  always_comb begin
    div_cnt_d = '0;
    pdm_cnt_d = '0;
    clk_d     = 1'b0;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    stb_d     = 1'b0;
    if (active_d) begin
      if (active_q) begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
        pdm_cnt_d = pdm_cnt_q;
        if (div_cnt_d == '0)
          pdm_cnt_d = (pdm_cnt_q == PDM_LAST) ? '0 : pdm_cnt_q + PDM_W'(1);
      end
      // Outputs derive from the next count so they line up with it when registered.
      clk_d  = (div_cnt_d < DIV_HALF);
      rise_d = (div_cnt_d == '0);
      fall_d = (div_cnt_d == DIV_HALF);
      stb_d  = rise_d && (pdm_cnt_d == PDM_LAST);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active_q  <= 1'b0;
      div_cnt_q <= '0;
      pdm_cnt_q <= '0;
      clk_q     <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      stb_q     <= 1'b0;
    end else begin
      active_q  <= active_d;
      div_cnt_q <= div_cnt_d;
      pdm_cnt_q <= pdm_cnt_d;
      clk_q     <= clk_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      stb_q     <= stb_d;
    end
  end

  assign sys_reset_n = sys_rst_n_q;
  assign pdm_clk     = clk_q;
  assign pdm_rise    = rise_q;
  assign pdm_fall    = fall_q;
  assign sample_stb  = stb_q;

endmodule
